// File: rtl/input_conditioner.sv
// input_conditioner: synchronizes raw keys and switches, debounces each key,
// and holds one press command (key index + switch snapshot) for a consumer.
module input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int NKEYS = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [NKEYS-1:0] keysn,
  input  logic [17:0]      sws,
  output logic [NKEYS-1:0] key_level,
  output logic [NKEYS-1:0] key_press,
  output logic [17:0]      sws_sync,
  output logic             cmd_valid,
  input  logic             cmd_ready,
  output logic [1:0]       cmd_key,
  output logic [17:0]      cmd_data,
  output logic             cmd_drop
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES);
  typedef enum logic [1:0] {RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT} state_e;
  logic [NKEYS-1:0] keys_meta_q, keys_sync_q;
  logic [17:0] sws_meta_q, sws_sync_q;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      keys_meta_q <= '1;
      keys_sync_q <= '1;
      sws_meta_q  <= '0;
      sws_sync_q  <= '0;
    end else begin
      keys_meta_q <= keysn;
      keys_sync_q <= keys_meta_q;
      sws_meta_q  <= sws;
      sws_sync_q  <= sws_meta_q;
    end
  end
  assign sws_sync = sws_sync_q;
  for (genvar k = 0; k < NKEYS; k++) begin : g_key
    state_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic press_q, press_d;
    logic pressed;
    assign pressed = ~keys_sync_q[k];
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        state_q <= RELEASED;
        cnt_q   <= '0;
        press_q <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        press_q <= press_d;
      end
    end
    // Counting only advances below CMAX, so the counter saturates rather than wraps.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      press_d = 1'b0;
      case (state_q)
        RELEASED: if (pressed) begin
          state_d = PRESS_WAIT;
          cnt_d   = CW'(1);
        end
        PRESS_WAIT: if (!pressed) begin
          state_d = RELEASED;
          cnt_d   = '0;
        end else if (cnt_q == CMAX) begin
          state_d = PRESSED;
          cnt_d   = '0;
          press_d = 1'b1;
        end else cnt_d = cnt_q + CW'(1);
        PRESSED: if (!pressed) begin
          state_d = RELEASE_WAIT;
          cnt_d   = CW'(1);
        end
        RELEASE_WAIT: if (pressed) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == CMAX) begin
          state_d = RELEASED;
          cnt_d   = '0;
        end else cnt_d = cnt_q + CW'(1);
        default: begin
          state_d = RELEASED;
          cnt_d   = '0;
        end
      endcase
    end
    assign key_level[k] = (state_q == PRESSED) || (state_q == RELEASE_WAIT);
    assign key_press[k] = press_q;
  end
  logic cmd_valid_q, cmd_valid_d, cmd_drop_q, cmd_drop_d;
  logic [1:0] cmd_key_q, cmd_key_d, first_idx;
  logic [17:0] cmd_data_q, cmd_data_d;
  logic any_press, multi_press, accept, load;
  always_comb begin
    first_idx = '0;
    for (int i = NKEYS - 1; i >= 0; i--) if (key_press[i]) first_idx = 2'(i);
  end
  assign any_press   = |key_press;
  assign multi_press = |(key_press & (key_press - NKEYS'(1)));
  assign accept      = ~cmd_valid_q | cmd_ready;
  assign load        = any_press & accept;
  assign cmd_valid_d = any_press | (cmd_valid_q & ~cmd_ready);
  assign cmd_key_d   = load ? first_idx : cmd_key_q;
  assign cmd_data_d  = load ? sws_sync_q : cmd_data_q;
  // A press is lost either because the slot is busy or because a lower key won.
  assign cmd_drop_d  = cmd_drop_q | (any_press & ~accept) | (multi_press & accept);
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cmd_valid_q <= 1'b0;
      cmd_key_q   <= '0;
      cmd_data_q  <= '0;
      cmd_drop_q  <= 1'b0;
    end else begin
      cmd_valid_q <= cmd_valid_d;
      cmd_key_q   <= cmd_key_d;
      cmd_data_q  <= cmd_data_d;
      cmd_drop_q  <= cmd_drop_d;
    end
  end
  assign cmd_valid = cmd_valid_q;
  assign cmd_key   = cmd_key_q;
  assign cmd_data  = cmd_data_q;
  assign cmd_drop  = cmd_drop_q;
endmodule

// File: tb/tb_input_conditioner.sv
// tb_input_conditioner: directed scenarios plus random key/switch/ready traffic,
// scored against a run-length debounce model and a command queue.
module tb_input_conditioner;
  localparam int D = 4;
  localparam int NK = 4;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic [NK-1:0] keysn = '1;
  logic [17:0] sws = '0;
  logic cmd_ready = 1'b0;
  logic [NK-1:0] key_level, key_press;
  logic [17:0] sws_sync, cmd_data;
  logic cmd_valid, cmd_drop;
  logic [1:0] cmd_key;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  input_conditioner #(.DEBOUNCE_CYCLES(D), .NKEYS(NK)) dut (
    .clk(clk), .rstn(rstn), .keysn(keysn), .sws(sws),
    .key_level(key_level), .key_press(key_press), .sws_sync(sws_sync),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_key(cmd_key),
    .cmd_data(cmd_data), .cmd_drop(cmd_drop)
  );
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 30) $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask
  // Reference: a key flips its accepted level after D+1 consecutive synchronized
  // samples that disagree with it; presses compete for a single command slot.
  typedef struct { logic [1:0] key; logic [17:0] data; } cmd_t;
  cmd_t exp_q[$];
  logic [NK-1:0] m_s1, m_s2, m_lvl, m_press, m_np;
  logic [17:0] m_w1, m_w2;
  int m_run [NK];
  logic m_valid, m_drop;
  int m_n, m_first;
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_s1 = '1; m_s2 = '1; m_w1 = '0; m_w2 = '0;
      m_lvl = '0; m_press = '0; m_valid = 1'b0; m_drop = 1'b0;
      foreach (m_run[i]) m_run[i] = 0;
      exp_q.delete();
    end else begin
      m_n = $countones(m_press);
      m_first = -1;
      for (int k = 0; k < NK; k++) if (m_press[k] && m_first < 0) m_first = k;
      if (m_n > 0) begin
        if (!m_valid || cmd_ready) begin
          exp_q.push_back('{key: 2'(m_first), data: m_w2});
          m_valid = 1'b1;
          if (m_n > 1) m_drop = 1'b1;
        end else m_drop = 1'b1;
      end else if (cmd_ready) m_valid = 1'b0;
      m_np = '0;
      for (int k = 0; k < NK; k++) begin
        if (!m_s2[k] != m_lvl[k]) begin
          m_run[k]++;
          if (m_run[k] == D + 1) begin
            m_lvl[k] = !m_s2[k];
            m_run[k] = 0;
            m_np[k] = m_lvl[k];
          end
        end else m_run[k] = 0;
      end
      m_press = m_np;
      m_s2 = m_s1; m_s1 = keysn;
      m_w2 = m_w1; m_w1 = sws;
    end
  end
  always @(negedge clk) begin
    #1;
    if (rstn) begin
      check("key_level", 32'(key_level), 32'(m_lvl));
      check("key_press", 32'(key_press), 32'(m_press));
      check("sws_sync", 32'(sws_sync), 32'(m_w2));
      check("cmd_drop", 32'(cmd_drop), 32'(m_drop));
      check("cmd_valid", 32'(cmd_valid), 32'(m_valid));
      if (cmd_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          if (errors <= 30) $display("FAIL cmd_unexpected: key %0d data %0h presented, none expected at t=%0t", cmd_key, cmd_data, $time);
        end else begin
          check("cmd_key", 32'(cmd_key), 32'(exp_q[0].key));
          check("cmd_data", 32'(cmd_data), 32'(exp_q[0].data));
          if (cmd_ready) void'(exp_q.pop_front());
        end
      end
    end
  end
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic do_reset();
    rstn = 1'b0;
    tick(2);
    rstn = 1'b1;
  endtask
  task automatic wait_valid(input string name);
    int n = 0;
    while (!cmd_valid && n < 40) begin
      tick(1);
      n++;
    end
    check(name, 32'(cmd_valid), 32'd1);
  endtask
  task automatic check_all_zero(input string name);
    check({name, "_level"}, 32'(key_level), 32'd0);
    check({name, "_press"}, 32'(key_press), 32'd0);
    check({name, "_sws"}, 32'(sws_sync), 32'd0);
    check({name, "_valid"}, 32'(cmd_valid), 32'd0);
    check({name, "_key"}, 32'(cmd_key), 32'd0);
    check({name, "_data"}, 32'(cmd_data), 32'd0);
    check({name, "_drop"}, 32'(cmd_drop), 32'd0);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
  initial begin
    sws = 18'h3C3C3;
    tick(3);
    check_all_zero("reset");
    rstn = 1'b1;
    // Single key held: pulse exactly at edge 2+D.
    tick(1);
    sws = 18'h12345;
    keysn = 4'b1110;
    for (int e = 0; e < 8; e++) begin
      @(posedge clk);
      #1;
      check("press_edge", 32'(key_press), (e == 6) ? 32'd1 : 32'd0);
    end
    check("single_level", 32'(key_level), 32'd1);
    check("single_valid", 32'(cmd_valid), 32'd1);
    check("single_key", 32'(cmd_key), 32'd0);
    check("single_data", 32'(cmd_data), 32'h12345);
    tick(1);
    cmd_ready = 1'b1;
    keysn = 4'b1111;
    tick(12);
    cmd_ready = 1'b0;
    // Glitchy key must never be accepted.
    keysn = 4'b1101; tick(3);
    keysn = 4'b1111; tick(1);
    keysn = 4'b1101;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check("glitch_press", 32'(key_press), 32'd0);
    end
    keysn = 4'b1111;
    tick(10);
    check("glitch_level", 32'(key_level), 32'd0);
    check("glitch_valid", 32'(cmd_valid), 32'd0);
    // Back-pressured command holds steady until the handshake.
    do_reset();
    sws = 18'h2AAAA;
    keysn = 4'b1011;
    wait_valid("hold_valid_rise");
    keysn = 4'b1111;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      check("hold_valid", 32'(cmd_valid), 32'd1);
      check("hold_key", 32'(cmd_key), 32'd2);
      check("hold_data", 32'(cmd_data), 32'h2AAAA);
    end
    cmd_ready = 1'b1;
    tick(1);
    check("hold_valid_clear", 32'(cmd_valid), 32'd0);
    cmd_ready = 1'b0;
    tick(10);
    // Keys 1 and 3 together: lowest wins, the other is dropped.
    do_reset();
    keysn = 4'b0101;
    wait_valid("simul_valid");
    check("simul_key", 32'(cmd_key), 32'd1);
    check("simul_drop", 32'(cmd_drop), 32'd1);
    keysn = 4'b1111;
    // Press while a command is pending and unready is discarded.
    do_reset();
    sws = 18'h15555;
    keysn = 4'b1011;
    wait_valid("busy_valid");
    keysn = 4'b1111;
    tick(12);
    check("busy_drop_before", 32'(cmd_drop), 32'd0);
    sws = 18'h3FFFF;
    keysn = 4'b1110;
    tick(10);
    check("busy_drop", 32'(cmd_drop), 32'd1);
    check("busy_key", 32'(cmd_key), 32'd2);
    check("busy_data", 32'(cmd_data), 32'h15555);
    keysn = 4'b1111;
    tick(12);
    // Reset in the middle of a key0 debounce with a command still pending.
    keysn = 4'b1110;
    repeat (5) @(posedge clk);
    #2;
    rstn = 1'b0;
    #1;
    check_all_zero("async_reset");
    tick(1);
    rstn = 1'b1;
    for (int e = 0; e < 8; e++) begin
      @(posedge clk);
      #1;
      check("rst_press_edge", 32'(key_press), (e == 6) ? 32'd1 : 32'd0);
    end
    tick(1);
    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      tick(1);
      for (int k = 0; k < NK; k++) if ($urandom_range(0, 7) == 0) keysn[k] = ~keysn[k];
      if ($urandom_range(0, 7) == 0) sws = 18'($urandom);
      cmd_ready = (c % 600 < 300) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 799) == 0) do_reset();
    end
    tick(1);
    keysn = '1;
    cmd_ready = 1'b1;
    tick(20);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/input_conditioner.md
INPUT_CONDITIONER -- requirements
Module: input_conditioner

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 16, meaning consecutive stable synchronized cycles required to accept a key level change (legal range 2..65535).
REQ-002 SHALL have parameter NKEYS, default 4, meaning number of push-button inputs.
REQ-003 SHALL have port clk  input  1  system clock; all state on rising edge.
REQ-004 SHALL have port rstn  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port keysn  input  NKEYS  raw asynchronous push-buttons, active-low (0 = pressed).
REQ-006 SHALL have port sws  input  18  raw asynchronous slide switches.
REQ-007 SHALL have port key_level  output  NKEYS  debounced key state, active-high (1 = pressed).
REQ-008 SHALL have port key_press  output  NKEYS  one-cycle pulse per accepted press.
REQ-009 SHALL have port sws_sync  output  18  two-flop synchronized switches.
REQ-010 SHALL have port cmd_valid  output  1  command pending for downstream consumer.
REQ-011 SHALL have port cmd_ready  input  1  downstream accepts command when high with cmd_valid.
REQ-012 SHALL have port cmd_key  output  2  index of key that generated the command.
REQ-013 SHALL have port cmd_data  output  18  sws_sync snapshot taken at the press.
REQ-014 SHALL have port cmd_drop  output  1  sticky flag: at least one press lost.

Function
REQ-015 SHALL pass every keysn and sws bit through a two-flop synchronizer; no other logic may sample raw inputs.
REQ-016 SHALL implement, per key, a four-state FSM: RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT.
REQ-017 RELEASED -> PRESS_WAIT when synchronized key reads pressed; counter cleared to 1.
REQ-018 PRESS_WAIT: counter increments each cycle key stays pressed; reverts to RELEASED with counter cleared on any released sample (glitch rejection).
REQ-019 PRESS_WAIT -> PRESSED when counter reaches DEBOUNCE_CYCLES; key_level bit set and key_press bit high for exactly that one cycle.
REQ-020 PRESSED/RELEASE_WAIT mirror REQ-017..019 for release; release produces no pulse, clears key_level in the cycle the count completes.
REQ-021 Counter width SHALL be clog2(DEBOUNCE_CYCLES+1); counter saturates, never wraps.
REQ-022 Latency: keysn stable-low sampled at edge 0 -> key_press high from edge 2+DEBOUNCE_CYCLES for one cycle.
REQ-023 On any key_press cycle with cmd_valid low (or cmd_valid high and cmd_ready high), SHALL load cmd_key, cmd_data <= sws_sync, cmd_valid <= 1 on next edge.
REQ-024 Simultaneous presses in one cycle: lowest index captured; every other pressed bit sets cmd_drop.
REQ-025 cmd_valid SHALL stay high and cmd_key/cmd_data SHALL stay stable until a cycle with cmd_ready high; cmd_valid clears next edge unless REQ-023 reloads it.
REQ-026 Press while cmd_valid high and cmd_ready low: press discarded, cmd_drop set; held command unchanged.
REQ-027 cmd_drop SHALL remain set until reset.
REQ-028 cmd_ready while cmd_valid low SHALL have no effect.

Reset
REQ-029 rstn low SHALL asynchronously force: keysn synchronizer flops to 1, sws synchronizer flops to 0, all FSMs RELEASED, counters 0, key_level 0, key_press 0, sws_sync 0, cmd_valid 0, cmd_key 0, cmd_data 0, cmd_drop 0.
REQ-030 Reset mid-debounce or with command pending SHALL discard all progress; after release, a still-held key requires full 2+DEBOUNCE_CYCLES before key_press.

Verification (DEBOUNCE_CYCLES=4)
REQ-031 keysn=4'b1110 held -> key_press=4'b0001 for exactly one cycle at edge 6, key_level[0]=1, cmd_valid=1, cmd_key=0, cmd_data=sws.
REQ-032 keysn[1] low 3 cycles, high 1, low 3 -> no key_press, key_level=0, cmd_valid=0.
REQ-033 sws=18'h2AAAA, press key2, cmd_ready=0 for 10 cycles then 1 -> cmd_key=2, cmd_data=18'h2AAAA stable throughout; cmd_valid low one edge after handshake.
REQ-034 keysn 1111 -> 0101 (keys 1,3 together) -> cmd_key=1, cmd_drop=1.
REQ-035 Command pending, cmd_ready=0, key0 pressed -> cmd_drop=1, cmd_key/cmd_data unchanged.
REQ-036 rstn pulsed low at edge 4 of a key0 press -> all outputs 0 immediately; key_press[0] at edge 6 after rstn release.
